led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
- Downstream consumer of the LEDip AXI4-Lite slave register bank (slv_reg0..3).
- Turns the control, period, pattern and duty registers into registered LED pin drive.
- Supports static, blink and rotate modes; all modes are gated by a PWM brightness stage.
- Returns a status word to the slave for readback.

Parameters:
NUM_LEDS, 4, number of LED outputs (1..32)
C_S_AXI_DATA_WIDTH, 32, register width from the slave
PWM_BITS, 8, PWM counter/duty resolution

Ports:
ACLK  in  1  system clock, same as the AXI slave clock
ARESET  in  1  synchronous, active-high reset
ctrl_reg  in  32  [0] enable; [2:1] mode (00 static, 01 blink, 10 rotate-left, 11 rotate-right); [8] pwm_en
period_reg  in  32  ACLK cycles per step tick; 0 is treated as 1
pattern_reg  in  32  [NUM_LEDS-1:0] LED pattern
duty_reg  in  32  [PWM_BITS-1:0] brightness duty
cfg_wr  in  1  one-cycle pulse on any slave register write
led_o  out  NUM_LEDS  LED drive, registered
step_tick_o  out  1  one-cycle pulse per step tick
status_o  out  32  [1:0] state code; [2] blink phase; [15:8] step count mod 256; others 0

Behaviour:
- Reset: all outputs 0. state=IDLE, prescaler=0, pwm_cnt=0, pat_q=0, phase=0, step_cnt=0. Reset has priority over every other input.
- Prescaler:
  - Runs only in RUN states. Counts 0..P-1, where P=max(period_reg,1).
  - At P-1: wrap to 0 and assert tick for that cycle. With P=1, tick fires every RUN cycle.
  - step_tick_o = tick registered, i.e. one cycle later.
  - step_cnt increments on each tick and wraps at 256.
- PWM:
  - pwm_cnt is free-running 0..2^PWM_BITS-1 in RUN states and held at 0 otherwise.
  - pwm_on = (pwm_cnt < duty). Duty 0 gives always off; duty 255 gives 255/256 on.
  - pwm_en=0 forces pwm_on=1.
- States (code): IDLE(0), LOAD(1), RUN(2), HOLD(3).
  - IDLE: led_o=0, counters cleared. enable=1 → LOAD.
  - LOAD: one cycle. pat_q<=pattern_reg, phase<=1, prescaler<=0, pwm_cnt<=0. → RUN.
  - RUN:
    - Static: eff=pat_q.
    - Blink: tick toggles phase; eff = phase ? pat_q : 0.
    - Rotate: tick rotates pat_q by 1 in the selected direction, wrapping the MSB/LSB across NUM_LEDS bits; eff=pat_q.
  - HOLD: entered from RUN when pwm_en=1 and duty=0. Counters freeze; led_o=0. Leaves to LOAD when duty≠0 or pwm_en=0.
  - enable=0 in any state → IDLE next cycle.
  - cfg_wr=1 with enable=1 in RUN/HOLD → LOAD next cycle (restart from the new pattern).
  - Simultaneous cfg_wr and tick: cfg_wr wins, no rotate/toggle.
- Output: led_o <= (state==RUN) ? eff & {NUM_LEDS{pwm_on}} : 0.
- Latency: enable sampled high at edge N → LOAD after N; RUN after N+1; led_o valid after N+2.
- Reset asserted mid-RUN: led_o=0 after the same edge.
- Pattern bits above NUM_LEDS-1 are ignored. Register changes without cfg_wr take effect only at the next LOAD, except duty, mode-independent pwm_en and enable, which are live.

Decomposition:
- Package led_pattern_pkg:
  - state enum led_state_t (IDLE/LOAD/RUN/HOLD, 2 bits).
  - Mode constants MODE_STATIC/BLINK/ROTL/ROTR.
  - Control bit index constants CTRL_EN=0, CTRL_MODE_LO=1, CTRL_PWM_EN=8.
  - Status field positions.
- Sub-module led_pwm_gen (PWM_BITS): clear/run inputs, duty in, pwm_on out.
- FSM, prescaler and pattern logic stay in the top.

Test Plan:
- Static: pattern=0xA, pwm_en=0, enable=1 → led_o=0xA two cycles after enable sampled; status_o[1:0]=2.
- Rotate-left: NUM_LEDS=4, pattern=0x1, period=3 → led_o sequence 1,2,4,8,1, one step every 3 cycles; step_tick_o pulses aligned; status_o[15:8] counts 1..5.
- Blink, period=0: pattern=0xF → led_o toggles 0xF/0x0 every cycle; status_o[2] toggles with it.
- PWM: duty=64, pwm_en=1, static 0xF → led_o high exactly 64 of each 256 cycles. duty=0 → HOLD (status 3), led_o=0. Duty back to 64 → LOAD then RUN.
- cfg_wr mid-rotate, coincident with a tick, pattern changed to 0x3 → LOAD next cycle, no rotate on that tick, led_o=0x3, then rotation continues 6,C,9.
- ARESET pulsed mid-RUN, and separately enable cleared → led_o=0, status_o=0 after one edge; re-enable restarts from LOAD.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared types and field positions for the LED pattern controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } led_state_t;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_ROTL   = 2'b10;
  localparam logic [1:0] MODE_ROTR   = 2'b11;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_PWM_EN  = 8;

  localparam int STAT_STATE_LO = 0;
  localparam int STAT_PHASE    = 2;
  localparam int STAT_STEP_LO  = 8;

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter with duty compare; pwm_on is combinational from the count.
// Latency: pwm_on follows duty/pwm_en in the same cycle; count advances once per run cycle.
// Backpressure: none.
module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                run,
  input  logic                pwm_en,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pwm_cnt <= '0;
    end else if (run) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign pwm_on = !pwm_en || (pwm_cnt < duty);

endmodule

// File: rtl/led_pattern_ctrl.sv
// Turns slave control/period/pattern/duty registers into registered LED drive with PWM gating.
// Latency: enable seen at edge N -> LOAD after N, RUN after N+1, led_o valid after N+2.
// Backpressure: none; cfg_wr restarts from LOAD, enable low returns to IDLE.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS           = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int PWM_BITS           = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] period_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] pattern_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] duty_reg,
  input  logic                          cfg_wr,
  output logic [NUM_LEDS-1:0]           led_o,
  output logic                          step_tick_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] status_o
);

  localparam logic [C_S_AXI_DATA_WIDTH-1:0] ONE = 1;

  led_state_t                    state_q, state_d;
  logic                          en, pwm_en, duty_zero, pwm_on, tick;
  logic [1:0]                    mode;
  logic [C_S_AXI_DATA_WIDTH-1:0] period_eff, presc_q;
  logic [NUM_LEDS-1:0]           pat_q, eff, pat_rotl, pat_rotr;
  logic                          phase_q;
  logic [7:0]                    step_cnt_q;
  logic                          unused_bits;

  assign en         = ctrl_reg[CTRL_EN];
  assign mode       = ctrl_reg[CTRL_MODE_LO +: 2];
  assign pwm_en     = ctrl_reg[CTRL_PWM_EN];
  assign duty_zero  = (duty_reg[PWM_BITS-1:0] == '0);
  assign period_eff = (period_reg == '0) ? ONE : period_reg;
  assign unused_bits = ^{ctrl_reg, pattern_reg, duty_reg};

  // >= rather than == so a shrinking period can never strand the prescaler past its wrap point
  assign tick = (state_q == RUN) && en && (presc_q >= period_eff - ONE);

  // Shift-or form keeps NUM_LEDS=1 legal (rotation degenerates to identity)
  assign pat_rotl = (pat_q << 1) | (pat_q >> (NUM_LEDS - 1));
  assign pat_rotr = (pat_q >> 1) | (pat_q << (NUM_LEDS - 1));

  always_comb begin
    eff = pat_q;
    if (mode == MODE_BLINK && !phase_q) begin
      eff = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN: begin
        if (cfg_wr)                     state_d = LOAD;
        else if (pwm_en && duty_zero)   state_d = HOLD;
      end
      HOLD: begin
        if (cfg_wr || !duty_zero || !pwm_en) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      pat_q       <= '0;
      phase_q     <= 1'b0;
      step_cnt_q  <= '0;
      led_o       <= '0;
      step_tick_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_tick_o <= tick;
      // Live enable gates the drive so clearing it darkens the LEDs on the very next edge
      led_o       <= (state_q == RUN && en) ? (eff & {NUM_LEDS{pwm_on}}) : '0;
      if (state_d == IDLE) begin
        presc_q    <= '0;
        phase_q    <= 1'b0;
        step_cnt_q <= '0;
      end else if (state_q == LOAD) begin
        pat_q   <= pattern_reg[NUM_LEDS-1:0];
        phase_q <= 1'b1;
        presc_q <= '0;
      end else if (state_q == RUN) begin
        presc_q <= tick ? '0 : presc_q + ONE;
        if (tick) begin
          step_cnt_q <= step_cnt_q + 8'd1;
          // A coincident cfg_wr restarts from the new pattern, so the step is not applied
          if (!cfg_wr) begin
            case (mode)
              MODE_BLINK: phase_q <= ~phase_q;
              MODE_ROTL:  pat_q   <= pat_rotl;
              MODE_ROTR:  pat_q   <= pat_rotr;
              default:    pat_q   <= pat_q;
            endcase
          end
        end
      end
    end
  end

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk    (ACLK),
    .rst    (ARESET),
    .clear  (state_q == IDLE || state_q == LOAD),
    .run    (state_q == RUN),
    .pwm_en (pwm_en),
    .duty   (duty_reg[PWM_BITS-1:0]),
    .pwm_on (pwm_on)
  );

  always_comb begin
    status_o = '0;
    status_o[STAT_STATE_LO +: 2] = state_q;
    status_o[STAT_PHASE]         = phase_q;
    status_o[STAT_STEP_LO +: 8]  = step_cnt_q;
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed-vector bench for led_pattern_ctrl: stimulus pushes expected outputs keyed by cycle,
// a negedge monitor pops and compares them.
module tb_led_pattern_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] ctrl_reg, period_reg, pattern_reg, duty_reg;
  logic        cfg_wr;
  logic [3:0]  led_o;
  logic        step_tick_o;
  logic [31:0] status_o;

  led_pattern_ctrl #(
    .NUM_LEDS           (4),
    .C_S_AXI_DATA_WIDTH (32),
    .PWM_BITS           (8)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .ctrl_reg    (ctrl_reg),
    .period_reg  (period_reg),
    .pattern_reg (pattern_reg),
    .duty_reg    (duty_reg),
    .cfg_wr      (cfg_wr),
    .led_o       (led_o),
    .step_tick_o (step_tick_o),
    .status_o    (status_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int          cyc;
    logic [3:0]  led;
    logic        tick;
    logic [31:0] st;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic push_exp(input int at, input logic [3:0] led, input logic tick,
                          input logic [31:0] st, input string nm);
    q.push_back('{at, led, tick, st, nm});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  function automatic logic [3:0] rot4(input logic [3:0] v, input int n);
    logic [3:0] r;
    r = v;
    for (int i = 0; i < n % 4; i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  // Monitor
  always @(negedge ACLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.cyc != cyc) begin
        miscompares++;
        $display("FAIL %s not sampled at cycle %0d (now %0d)", e.nm, e.cyc, cyc);
      end else if (led_o !== e.led || step_tick_o !== e.tick || status_o !== e.st) begin
        miscompares++;
        $display("FAIL %s cyc=%0d led=%h want %h tick=%b want %b status=%h want %h",
                 e.nm, cyc, led_o, e.led, step_tick_o, e.tick, status_o, e.st);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired with %0d vectors pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r, r2;
    ARESET = 1'b1; ctrl_reg = '0; period_reg = '0; pattern_reg = '0; duty_reg = '0; cfg_wr = 1'b0;
    step(3);
    push_exp(cyc, 4'h0, 1'b0, 32'h0, "reset");
    ARESET = 1'b0;
    push_exp(cyc + 1, 4'h0, 1'b0, 32'h0, "idle");
    step(1);

    // Static pattern, no PWM
    k = cyc;
    ctrl_reg = 32'h1; pattern_reg = 32'hFFFF_FFFA; period_reg = 32'd100;
    push_exp(k + 1, 4'h0, 1'b0, 32'h1, "static_load");
    push_exp(k + 2, 4'h0, 1'b0, 32'h6, "static_run0");
    push_exp(k + 3, 4'hA, 1'b0, 32'h6, "static_led");
    push_exp(k + 4, 4'hA, 1'b0, 32'h6, "static_led2");
    step(4);
    ctrl_reg = 32'h0;
    push_exp(cyc + 1, 4'h0, 1'b0, 32'h0, "static_disable");
    push_exp(cyc + 2, 4'h0, 1'b0, 32'h0, "static_idle");
    step(2);

    // Rotate-left, period 3
    k = cyc;
    ctrl_reg = 32'h5; pattern_reg = 32'h1; period_reg = 32'd3;
    push_exp(k + 1, 4'h0, 1'b0, 32'h1, "rotl_load");
    push_exp(k + 2, 4'h0, 1'b0, 32'h6, "rotl_run0");
    r = k + 2;
    for (int j = 1; j <= 17; j++)
      push_exp(r + j, rot4(4'h1, (j - 1) / 3), (j % 3 == 0), 32'h6 | (32'(j / 3) << 8), "rotl_seq");
    step(19);
    // cfg_wr coincides with the tick in cycle r+17
    cfg_wr = 1'b1; pattern_reg = 32'h3;
    push_exp(r + 18, 4'h2, 1'b1, 32'h605, "cfg_tick_load");
    push_exp(r + 19, 4'h0, 1'b0, 32'h606, "cfg_run0");
    step(1);
    cfg_wr = 1'b0;
    step(1);
    r2 = cyc;
    for (int j = 1; j <= 12; j++)
      push_exp(r2 + j, rot4(4'h3, (j - 1) / 3), (j % 3 == 0), 32'h6 | (32'(6 + j / 3) << 8), "cfg_rotl_seq");
    step(12);
    ctrl_reg = 32'h0;
    push_exp(cyc + 1, 4'h0, 1'b0, 32'h0, "rotl_disable");
    step(2);

    // Blink, period 0 behaves as 1
    k = cyc;
    ctrl_reg = 32'h3; pattern_reg = 32'hF; period_reg = 32'd0;
    push_exp(k + 1, 4'h0, 1'b0, 32'h1, "blink_load");
    push_exp(k + 2, 4'h0, 1'b0, 32'h6, "blink_run0");
    r = k + 2;
    for (int j = 1; j <= 8; j++)
      push_exp(r + j, (j % 2 == 1) ? 4'hF : 4'h0, 1'b1,
               32'h2 | ((j % 2 == 0) ? 32'h4 : 32'h0) | (32'(j) << 8), "blink_seq");
    step(10);
    ctrl_reg = 32'h0;
    push_exp(cyc + 1, 4'h0, 1'b0, 32'h0, "blink_disable");
    step(2);

    // PWM duty 64, then HOLD, resume, and reset mid-RUN
    k = cyc;
    ctrl_reg = 32'h101; pattern_reg = 32'hF; period_reg = 32'h0100_0000; duty_reg = 32'd64;
    push_exp(k + 1, 4'h0, 1'b0, 32'h1, "pwm_load");
    push_exp(k + 2, 4'h0, 1'b0, 32'h6, "pwm_run0");
    r = k + 2;
    for (int j = 1; j <= 300; j++)
      push_exp(r + j, ((j - 1) % 256 < 64) ? 4'hF : 4'h0, 1'b0, 32'h6, "pwm_duty64");
    step(302);
    duty_reg = 32'd0;
    for (int j = 301; j <= 305; j++)
      push_exp(r + j, 4'h0, 1'b0, 32'h7, "pwm_hold");
    step(5);
    duty_reg = 32'd64;
    push_exp(r + 306, 4'h0, 1'b0, 32'h5, "hold_to_load");
    push_exp(r + 307, 4'h0, 1'b0, 32'h6, "hold_resume_run");
    push_exp(r + 308, 4'hF, 1'b0, 32'h6, "hold_resume_led");
    push_exp(r + 309, 4'hF, 1'b0, 32'h6, "hold_resume_led2");
    push_exp(r + 310, 4'hF, 1'b0, 32'h6, "hold_resume_led3");
    step(5);
    ARESET = 1'b1;
    push_exp(r + 311, 4'h0, 1'b0, 32'h0, "reset_mid_run");
    step(1);
    ARESET = 1'b0;
    push_exp(r + 312, 4'h0, 1'b0, 32'h1, "reset_reload");
    push_exp(r + 313, 4'h0, 1'b0, 32'h6, "reset_rerun");
    push_exp(r + 314, 4'hF, 1'b0, 32'h6, "reset_reled");
    step(4);
    ctrl_reg = 32'h0;
    step(3);

    if (q.size() != 0) begin
      $display("FAIL pending_vectors left=%0d required=0", q.size());
      miscompares += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
